// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command controller:
// opcode encoding, FSM state encoding, datapath widths.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int RES_W  = 13;

    // Opcodes (same encoding as the ALU sel input)
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_MOD  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NAND = 4'h8;
    localparam logic [3:0] OP_NOR  = 4'h9;
    localparam logic [3:0] OP_XNOR = 4'hA;
    localparam logic [3:0] OP_SHL  = 4'hB;
    localparam logic [3:0] OP_SHR  = 4'hC;
    localparam logic [3:0] OP_NOT  = 4'hD;
    localparam logic [3:0] OP_INC  = 4'hE;
    localparam logic [3:0] OP_DEC  = 4'hF;

    // Controller FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_cmd_resp_reg.sv
// Response register: captures result/err on cap_i, registers zero/ovf flags.
// Ports: clk_i, rst_i, cap_i, data_i, err_i -> data_o, zero_o, ovf_o, err_o.
module alu_cmd_resp_reg
    import alu_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cap_i,
    input  logic [RES_W-1:0] data_i,
    input  logic             err_i,
    output logic [RES_W-1:0] data_o,
    output logic             zero_o,
    output logic             ovf_o,
    output logic             err_o
);

    logic [RES_W-1:0] data_q;
    logic             zero_q;
    logic             ovf_q;
    logic             err_q;

    // Flags are registered alongside the data so they read 0 out of reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else if (cap_i) begin
            data_q <= data_i;
            zero_q <= (data_i == '0);
            ovf_q  <= |data_i[RES_W-1:DATA_W];
            err_q  <= err_i;
        end
    end

    assign data_o = data_q;
    assign zero_o = zero_q;
    assign ovf_o  = ovf_q;
    assign err_o  = err_q;

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command-side controller for an 8-bit ALU: accumulator, registered ALU drive,
// settle wait, result capture. Ports: cmd_* in (valid/ready), res_* out
// (valid/ready), acc, alu_a/alu_b/alu_sel to the ALU, alu_result from it.
module alu_cmd_ctrl
    import alu_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter int ACC_WB      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [3:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic              res_zero,
    output logic              res_ovf,
    output logic              res_err,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [RES_W-1:0]  alu_result
);

    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [3:0]        sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              cap;
    logic [RES_W-1:0]  cap_data;
    logic              cap_err;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        cap      = 1'b0;
        cap_data = '0;
        cap_err  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_load) begin
                        acc_d    = cmd_data;
                        cap      = 1'b1;
                        cap_data = {{(RES_W-DATA_W){1'b0}}, cmd_data};
                        state_d  = ST_RESP;
                    end else if (is_div_op(cmd_op) && cmd_data == '0) begin
                        // Divide by zero never reaches the ALU
                        cap      = 1'b1;
                        cap_err  = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        a_d      = acc_q;
                        b_d      = cmd_data;
                        sel_d    = cmd_op;
                        cnt_d    = CNT_W'(EXEC_CYCLES - 1);
                        state_d  = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    cap      = 1'b1;
                    cap_data = alu_result;
                    if (ACC_WB != 0) acc_d = alu_result[DATA_W-1:0];
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    alu_cmd_resp_reg u_resp (
        .clk_i  (clk),
        .rst_i  (rst),
        .cap_i  (cap),
        .data_i (cap_data),
        .err_i  (cap_err),
        .data_o (res_data),
        .zero_o (res_zero),
        .ovf_o  (res_ovf),
        .err_o  (res_err)
    );

    // Reset forces IDLE, so gate ready with rst to keep it low during reset
    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign res_valid = (state_q == ST_RESP);
    assign acc       = acc_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_sel   = sel_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed scoreboard bench for alu_cmd_ctrl with a behavioural ALU
// attached to alu_a/alu_b/alu_sel -> alu_result.
module tb_alu_cmd_ctrl;
    import alu_pkg::*;

    localparam int EXEC = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_load = 1'b0;
    logic [3:0]  cmd_op = 4'h0;
    logic [7:0]  cmd_data = 8'h00;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [12:0] res_data;
    logic        res_zero;
    logic        res_ovf;
    logic        res_err;
    logic [7:0]  acc;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_sel;
    logic [12:0] alu_result;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    typedef struct packed {
        logic [12:0] data;
        logic        err;
        logic [7:0]  acc;
        logic        exec;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_cmd_ctrl #(.EXEC_CYCLES(EXEC), .ACC_WB(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_load   (cmd_load),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_zero   (res_zero),
        .res_ovf    (res_ovf),
        .res_err    (res_err),
        .acc        (acc),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result)
    );

    // Behavioural ALU standing in for the real instance
    always_comb begin
        alu_result = 13'h0;
        case (alu_sel)
            OP_ADD: alu_result = {5'h0, alu_a} + {5'h0, alu_b};
            OP_SUB: alu_result = {5'h0, alu_a} - {5'h0, alu_b};
            OP_MUL: alu_result = {5'h0, alu_a} * {5'h0, alu_b};
            OP_DIV: alu_result = (alu_b == 8'h0) ? 13'h0 : {5'h0, alu_a / alu_b};
            OP_MOD: alu_result = (alu_b == 8'h0) ? 13'h0 : {5'h0, alu_a % alu_b};
            OP_DEC: alu_result = {5'h0, alu_a} - 13'h1;
            default: alu_result = 13'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [12:0] d, input logic e,
                                input logic [7:0] a, input logic x);
        exp_t r;
        r.data = d;
        r.err  = e;
        r.acc  = a;
        r.exec = x;
        return r;
    endfunction

    task automatic send(input logic ld, input logic [3:0] op,
                        input logic [7:0] d, input exp_t e);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", 64'(n < 50), 64'd1);
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_op    = op;
        cmd_data  = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        // Junk on the fields after acceptance must not matter
        cmd_load  = 1'b0;
        cmd_op    = 4'h7;
        cmd_data  = 8'hA5;
    endtask

    task automatic check_resp(input string tag);
        exp_t e;
        chk({tag, "_sb"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_data"}, 64'(res_data), 64'(e.data));
            chk({tag, "_zero"}, 64'(res_zero), 64'(e.data == 13'h0));
            chk({tag, "_ovf"},  64'(res_ovf),  64'(|e.data[12:8]));
            chk({tag, "_err"},  64'(res_err),  64'(e.err));
            chk({tag, "_acc"},  64'(acc),      64'(e.acc));
        end
    endtask

    task automatic recv(input string tag);
        int lat = 0;
        bit ex;
        ex = (sb.size() > 0) ? sb[0].exec : 1'b0;
        @(negedge clk);
        while (!res_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_valid"}, 64'(res_valid), 64'd1);
        if (ex) chk({tag, "_lat"}, 64'(lat), 64'(EXEC));
        check_resp(tag);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk({tag, "_drop"}, 64'(res_valid), 64'd0);
        chk({tag, "_rdy"},  64'(cmd_ready), 64'd1);
    endtask

    function automatic logic [63:0] outs();
        return 64'({res_valid, res_zero, res_ovf, res_err, res_data,
                    acc, alu_a, alu_b, alu_sel});
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        chk("rst_outs", outs(), 64'd0);
        chk("rst_ready", 64'(cmd_ready), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(cmd_ready), 64'd1);

        // Load then add
        send(1'b1, 4'h0, 8'h05, mk(13'h0005, 1'b0, 8'h05, 1'b0));
        recv("load05");
        send(1'b0, OP_ADD, 8'h03, mk(13'h0008, 1'b0, 8'h08, 1'b1));
        recv("add03");

        // Full-width multiply
        send(1'b1, 4'h0, 8'hFF, mk(13'h00FF, 1'b0, 8'hFF, 1'b0));
        recv("loadFF");
        send(1'b0, OP_MUL, 8'hFF, mk(13'h1E01, 1'b0, 8'h01, 1'b1));
        recv("mulFF");

        // Underflow as 13-bit two's complement
        send(1'b1, 4'h0, 8'h03, mk(13'h0003, 1'b0, 8'h03, 1'b0));
        recv("load03");
        send(1'b0, OP_SUB, 8'h05, mk(13'h1FFE, 1'b0, 8'hFE, 1'b1));
        recv("sub05");
        send(1'b1, 4'h0, 8'h00, mk(13'h0000, 1'b0, 8'h00, 1'b0));
        recv("load00");
        send(1'b0, OP_DEC, 8'h00, mk(13'h1FFF, 1'b0, 8'hFF, 1'b1));
        recv("dec");

        // Divide by zero rejected, ALU drive untouched
        send(1'b1, 4'h0, 8'h09, mk(13'h0009, 1'b0, 8'h09, 1'b0));
        recv("load09");
        send(1'b0, OP_DIV, 8'h00, mk(13'h0000, 1'b1, 8'h09, 1'b0));
        recv("div0");
        chk("div0_sel", 64'(alu_sel), 64'(OP_DEC));
        chk("div0_a",   64'(alu_a),   64'h00);
        send(1'b0, OP_MOD, 8'h04, mk(13'h0001, 1'b0, 8'h01, 1'b1));
        recv("mod04");

        // Backpressure with a queued command
        send(1'b0, OP_ADD, 8'h22, mk(13'h0023, 1'b0, 8'h23, 1'b1));
        begin
            int n = 0;
            @(negedge clk);
            while (!res_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("bp_valid", 64'(res_valid), 64'd1);
        end
        check_resp("bp");
        cmd_valid = 1'b1;
        cmd_load  = 1'b1;
        cmd_data  = 8'h77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_data",  64'(res_data),  64'h023);
            chk("bp_hold_flags", 64'({res_valid, res_zero, res_ovf, res_err}), 64'b1000);
            chk("bp_hold_rdy",   64'(cmd_ready), 64'd0);
            chk("bp_hold_acc",   64'(acc),       64'h23);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("bp_rel_valid", 64'(res_valid), 64'd0);
        chk("bp_rel_rdy",   64'(cmd_ready), 64'd1);
        chk("bp_rel_acc",   64'(acc),       64'h23);
        sb.push_back(mk(13'h0077, 1'b0, 8'h77, 1'b0));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        recv("queued_load");

        // Reset during EXEC
        send(1'b0, OP_ADD, 8'h01, mk(13'h0078, 1'b0, 8'h78, 1'b1));
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        chk("mid_rst_outs",  outs(), 64'd0);
        chk("mid_rst_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rel_ready", 64'(cmd_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rel_novalid", 64'(res_valid), 64'd0);
        end
        send(1'b1, 4'h0, 8'h3C, mk(13'h003C, 1'b0, 8'h3C, 1'b0));
        recv("post_rst_load");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
